// File: rtl/ysyx_22040127_div_unit.sv
`default_nettype none
// =============================================================================
// Module   : ysyx_22040127_div_unit
// Purpose  : Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
// Revision : 1.0
// =============================================================================

module ysyx_22040127_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int c_HALF = XLEN / 2;
    localparam int c_CW   = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_div;
    logic [c_CW-1:0]   r_cnt;
    logic              r_is_rem;
    logic              r_word;
    logic              r_neg_q;
    logic              r_neg_r;

    // Word results are always sign-extended from bit 31, signed or not.
    function automatic logic [XLEN-1:0] f_fmt(input logic w, input logic [XLEN-1:0] x);
        return w ? {{c_HALF{x[c_HALF-1]}}, x[c_HALF-1:0]} : x;
    endfunction

    // ---------------------------------------------------------------- operand prep
    logic            w_signed;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN:0]   w_a_x;
    logic [XLEN:0]   w_b_x;
    logic [XLEN:0]   w_a_mag_x;
    logic [XLEN:0]   w_b_mag_x;
    logic [XLEN-1:0] w_dividend;
    logic            w_b_zero;
    logic            w_a_min;
    logic            w_b_m1;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;
    logic [c_CW-1:0] w_cnt_init;

    always_comb begin
        w_signed = ~in_op[0];
        w_a = in_word ? {{c_HALF{w_signed & in_src1[c_HALF-1]}}, in_src1[c_HALF-1:0]} : in_src1;
        w_b = in_word ? {{c_HALF{w_signed & in_src2[c_HALF-1]}}, in_src2[c_HALF-1:0]} : in_src2;
        w_a_neg = w_signed & w_a[XLEN-1];
        w_b_neg = w_signed & w_b[XLEN-1];
        // One extra bit keeps the most-negative magnitude from wrapping.
        w_a_x     = {w_a_neg, w_a};
        w_b_x     = {w_b_neg, w_b};
        w_a_mag_x = w_a_neg ? -w_a_x : w_a_x;
        w_b_mag_x = w_b_neg ? -w_b_x : w_b_x;
        // Word dividends sit in the upper half so both widths shift out from the MSB.
        w_dividend = in_word ? {w_a_mag_x[c_HALF-1:0], {c_HALF{1'b0}}} : w_a_mag_x[XLEN-1:0];

        w_b_zero = in_word ? (in_src2[c_HALF-1:0] == '0) : (in_src2 == '0);
        w_a_min  = in_word ? (in_src1[c_HALF-1:0] == {1'b1, {(c_HALF-1){1'b0}}})
                           : (in_src1 == {1'b1, {(XLEN-1){1'b0}}});
        w_b_m1   = in_word ? (&in_src2[c_HALF-1:0]) : (&in_src2);
        w_special = w_b_zero | (w_signed & w_a_min & w_b_m1);

        if (in_op[1]) begin
            w_spec_res = w_b_zero ? f_fmt(in_word, in_src1) : '0;
        end else begin
            w_spec_res = w_b_zero ? '1 : f_fmt(in_word, in_src1);
        end
        w_cnt_init = in_word ? c_CW'(c_HALF - 1) : c_CW'(XLEN - 1);
    end

    // ---------------------------------------------------------------- iteration
    logic [XLEN:0]   w_shift;
    logic [XLEN+1:0] w_trial;
    logic            w_borrow;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;
    logic [XLEN-1:0] w_res;
    logic            w_unused;

    always_comb begin
        w_shift  = {r_rem, r_quo[XLEN-1]};
        w_trial  = {1'b0, w_shift} - {2'b00, r_div};
        w_borrow = w_trial[XLEN+1];
        w_rem_nx = w_borrow ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
        w_quo_nx = {r_quo[XLEN-2:0], ~w_borrow};
        w_q_fin  = r_neg_q ? -w_quo_nx : w_quo_nx;
        w_r_fin  = r_neg_r ? -w_rem_nx : w_rem_nx;
        w_res    = f_fmt(r_word, r_is_rem ? w_r_fin : w_q_fin);
        w_unused = w_trial[XLEN] ^ w_a_mag_x[XLEN] ^ w_b_mag_x[XLEN];
    end

    // ---------------------------------------------------------------- control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_is_rem   <= 1'b0;
            r_word     <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (flush) begin
            r_state   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_is_rem <= in_op[1];
                        r_word   <= in_word;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        in_ready <= 1'b0;
                        if (w_special) begin
                            out_result <= w_spec_res;
                            out_valid  <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_dividend;
                            r_div   <= w_b_mag_x[XLEN-1:0];
                            r_cnt   <= w_cnt_init;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - c_CW'(1);
                    if (r_cnt == '0) begin
                        out_result <= w_res;
                        out_valid  <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ysyx_22040127_div_unit.md
Name: ysyx_22040127_div_unit

Overview:
Multi-cycle iterative integer divider for RV64M DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW. It is the responder the execute stage issues division to in place of combinational "/" and "%". Execute stalls on the valid/ready handshake until the result returns.
The unit is radix-2 restoring, one quotient bit per cycle, and resolves RISC-V special cases in a single cycle.

Parameters:
XLEN, 64, operand/result width; word mode operates on XLEN/2 low bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous abort of any in-flight op
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
in_op  input  2  00 div, 01 divu, 10 rem, 11 remu
in_word  input  1  1 = W variant (operate on [31:0], sign-extend result)
in_src1  input  XLEN  dividend
in_src2  input  XLEN  divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  XLEN  quotient or remainder per in_op

Behaviour:
- Reset (rst low, async): state IDLE, out_valid=0, out_result=0, in_ready=1, all internal registers 0.
- States:
  - IDLE: in_ready=1. On in_valid, the request is accepted at that edge. Op, word and sign flags are latched.
    - Next state is DONE if the op is special, otherwise CALC with counter=N-1.
    - N=32 if in_word, else 64.
  - CALC: in_ready=0.
    - Each edge shifts {rem,quo} left 1 and trial-subtracts |divisor|. If there is no borrow, rem is replaced and the quotient bit is 1.
    - On the edge where counter==0, the final result is registered and the state moves to DONE.
  - DONE: out_valid=1 and out_result stable. On out_valid&out_ready the state moves to IDLE. out_result holds until the next result is written.
- Latency, counted from the accept edge to the first cycle out_valid is high:
  - Normal 64-bit op: 64 cycles.
  - Normal word op: 32 cycles.
  - Special case: 1 cycle.
  - No back-to-back accept: in_ready is low in CALC and DONE. The earliest next accept is the cycle after the result handshake.
- Operand prep:
  - Word mode takes src[31:0]. For signed ops these bits are treated as signed 32-bit.
  - Signed ops divide magnitudes. The quotient is negated if the dividend and divisor signs differ. The remainder takes the dividend's sign.
  - The most-negative dividend magnitude must be handled in N+1-bit arithmetic; no overflow wrap is permitted.
- Special cases (width N; s1 and s2 are the N-bit operands):
  - Divisor zero: quotient = all ones (-1), remainder = s1.
  - Signed overflow (s1 = most-negative N-bit value, s2 = -1): quotient = s1, remainder = 0.
- Result width: word results are sign-extended from bit 31 to XLEN for all four word ops, including divuw and remuw.
- flush: takes priority over every transition.
  - At the next edge the state becomes IDLE and out_valid=0; any in-flight result is discarded.
  - A request presented in the same cycle as flush is not accepted.
- out_ready is ignored unless out_valid=1. in_* inputs are ignored unless IDLE.
- Backpressure: the state stays in DONE indefinitely while out_ready=0, with no change to out_result.
- Reset asserted mid-CALC or mid-DONE: immediate return to the reset values. Nothing is retained.

Test Plan:
- div, 64-bit, src1=-7 (0xFFFF_FFFF_FFFF_FFF9), src2=2, out_ready=1.
  - out_valid high 64 cycles after accept; result 0xFFFF_FFFF_FFFF_FFFD (-3).
  - Repeat with rem: result 0xFFFF_FFFF_FFFF_FFFF (-1).
- divu by zero, src1=0x1234, src2=0 -> result 0xFFFF_FFFF_FFFF_FFFF, 1 cycle after accept.
  - remu with the same operands -> 0x1234.
- divw overflow, src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_8000_0000, 1 cycle.
  - remw with the same operands -> 0.
- divuw, src1=0xFFFF_FFFF, src2=1 -> result 0xFFFF_FFFF_FFFF_FFFF after 32 cycles.
  - Upper src bits set to garbage must not affect the result.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises -> out_valid and out_result stable and in_ready=0.
  - Then out_ready=1 -> IDLE next cycle, in_ready=1.
- flush at cycle 20 of a 64-bit div -> out_valid never asserts, in_ready=1 next cycle.
  - A new divu 100/7 then returns 14.
  - Separately, rst low mid-CALC -> all outputs at reset values asynchronously.
